// File: rtl/pong_field_engine.sv
// pong_field_engine: ball/paddle/score engine for the LED-matrix pong game.
// Owns the game FSM, ball motion with wall and paddle bounces, scoring, and
// renders one registered display row per cycle.
// Optional feature macro: PONG_EDGE_DEFLECT_EN (paddle edge hits steer dx).
module pong_field_engine #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int BIT_OF_W   = 3,
  parameter int BIT_OF_H   = 3,
  parameter int SIZE       = 2,
  parameter int WIN_SCORE  = 5,
  parameter int POINT_HOLD = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic [BIT_OF_W-1:0] player_top,
  input  logic [BIT_OF_W-1:0] player_down,
  input  logic [BIT_OF_H-1:0] row_sel,
  output logic [WIDTH-1:0]    row_out,
  output logic [BIT_OF_W-1:0] ball_x,
  output logic [BIT_OF_H-1:0] ball_y,
  output logic [3:0]          score_top,
  output logic [3:0]          score_down,
  output logic                hit,
  output logic                game_over
);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  localparam logic [BIT_OF_W-1:0] X_MID  = BIT_OF_W'(WIDTH/2);
  localparam logic [BIT_OF_W-1:0] X_MAX  = BIT_OF_W'(WIDTH-1);
  localparam logic [BIT_OF_W-1:0] P_MAX  = BIT_OF_W'(WIDTH-SIZE);
  localparam logic [BIT_OF_W-1:0] P_LAST = BIT_OF_W'(SIZE-1);
  localparam logic [BIT_OF_H-1:0] Y_MID  = BIT_OF_H'(HEIGHT/2);
  localparam logic [BIT_OF_H-1:0] Y_BOT  = BIT_OF_H'(HEIGHT-1);
  localparam logic [BIT_OF_H-1:0] Y_NEAR = BIT_OF_H'(HEIGHT-2);
  localparam logic [3:0]          WIN    = 4'(WIN_SCORE);
  localparam logic [7:0]          HOLD_LAST = 8'(POINT_HOLD-1);

  state_t                state, state_n;
  logic [BIT_OF_W-1:0]   x_n;
  logic [BIT_OF_H-1:0]   y_n;
  logic                  dx_neg, dx_neg_n, dy_neg, dy_neg_n;
  logic                  serve_up, serve_up_n;   // next serve heads toward row 0
  logic [3:0]            score_t_n, score_d_n;
  logic [7:0]            hold_cnt, hold_n;
  logic                  hit_n;
  logic [BIT_OF_W-1:0]   pt_c, pd_c, pad_lo, nx;
  logic                  step_dx_neg, at_top, at_down, covered;
  logic [WIDTH-1:0]      row_n;

  function automatic logic [WIDTH-1:0] pmask(input logic [BIT_OF_W-1:0] p);
    pmask = '0;
    for (int i = 0; i < WIDTH; i++) pmask[i] = (i >= int'(p)) && (i < int'(p) + SIZE);
  endfunction

  // Paddle clamp, horizontal step with wall bounce, and paddle coverage test
  always_comb begin
    pt_c = (player_top  > P_MAX) ? P_MAX : player_top;
    pd_c = (player_down > P_MAX) ? P_MAX : player_down;
    step_dx_neg = dx_neg;
    if (!dx_neg) begin
      if (ball_x == X_MAX) begin nx = ball_x - BIT_OF_W'(1); step_dx_neg = 1'b1; end
      else nx = ball_x + BIT_OF_W'(1);
    end else begin
      if (ball_x == '0) begin nx = BIT_OF_W'(1); step_dx_neg = 1'b0; end
      else nx = ball_x - BIT_OF_W'(1);
    end
    at_top  = (ball_y == BIT_OF_H'(1)) && dy_neg;
    at_down = (ball_y == Y_NEAR) && !dy_neg;
    pad_lo  = at_top ? pt_c : pd_c;
    covered = (nx >= pad_lo) && (nx <= pad_lo + P_LAST);
  end

  // Game FSM next-state and ball/score updates
  always_comb begin
    state_n    = state;
    x_n        = ball_x;
    y_n        = ball_y;
    dx_neg_n   = dx_neg;
    dy_neg_n   = dy_neg;
    serve_up_n = serve_up;
    score_t_n  = score_top;
    score_d_n  = score_down;
    hold_n     = hold_cnt;
    hit_n      = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_SERVE;
        x_n = X_MID; y_n = Y_MID; dx_neg_n = 1'b0; dy_neg_n = serve_up;
      end
      S_SERVE: if (tick) state_n = S_PLAY;
      S_PLAY: if (tick) begin
        x_n = nx;
        dx_neg_n = step_dx_neg;
        if (at_top || at_down) begin
          if (covered) begin
            dy_neg_n = !dy_neg;
            hit_n    = 1'b1;
`ifdef PONG_EDGE_DEFLECT_EN
            if (nx == pad_lo) dx_neg_n = 1'b1;
            else if (nx == pad_lo + P_LAST) dx_neg_n = 1'b0;
`endif
          end else begin
            // Miss: ball enters the goal row, the other side scores
            y_n     = at_top ? '0 : Y_BOT;
            state_n = S_POINT;
            if (at_top) begin
              score_d_n  = (score_down == 4'd15) ? score_down : score_down + 4'd1;
              serve_up_n = 1'b1;
            end else begin
              score_t_n  = (score_top == 4'd15) ? score_top : score_top + 4'd1;
              serve_up_n = 1'b0;
            end
          end
        end else begin
          y_n = dy_neg ? ball_y - BIT_OF_H'(1) : ball_y + BIT_OF_H'(1);
        end
      end
      S_POINT: if (tick) begin
        if (hold_cnt == HOLD_LAST) begin
          hold_n = '0;
          if (score_top == WIN || score_down == WIN) state_n = S_OVER;
          else begin
            state_n = S_SERVE;
            x_n = X_MID; y_n = Y_MID; dx_neg_n = 1'b0; dy_neg_n = serve_up;
          end
        end else hold_n = hold_cnt + 8'd1;
      end
      S_OVER: if (start) begin
        state_n = S_SERVE;
        score_t_n = '0; score_d_n = '0; serve_up_n = 1'b0;
        x_n = X_MID; y_n = Y_MID; dx_neg_n = 1'b0; dy_neg_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Row renderer: paddles on the goal rows, ball everywhere except IDLE
  always_comb begin
    row_n = '0;
    if (row_sel == '0)   row_n = pmask(pt_c);
    if (row_sel == Y_BOT) row_n = row_n | pmask(pd_c);
    if (state != S_IDLE && row_sel == ball_y) row_n[ball_x] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ball_x     <= X_MID;
      ball_y     <= Y_MID;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      serve_up   <= 1'b0;
      score_top  <= '0;
      score_down <= '0;
      hold_cnt   <= '0;
      hit        <= 1'b0;
      row_out    <= '0;
    end else begin
      state      <= state_n;
      ball_x     <= x_n;
      ball_y     <= y_n;
      dx_neg     <= dx_neg_n;
      dy_neg     <= dy_neg_n;
      serve_up   <= serve_up_n;
      score_top  <= score_t_n;
      score_down <= score_d_n;
      hold_cnt   <= hold_n;
      hit        <= hit_n;
      row_out    <= row_n;
    end
  end

  assign game_over = (state == S_OVER);

endmodule

// File: tb/tb_pong_field_engine.sv
// Randomized bench for pong_field_engine against an integer game model.
module tb_pong_field_engine;
  localparam int W = 8, H = 8, S = 2, WIN = 5, HOLD = 3;

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
  logic [2:0] player_top = '0, player_down = '0, row_sel = '0;
  logic [7:0] row_out;
  logic [2:0] ball_x, ball_y;
  logic [3:0] score_top, score_down;
  logic       hit, game_over;

  int n_run = 0, n_fail = 0;

  pong_field_engine #(.WIDTH(W), .HEIGHT(H), .BIT_OF_W(3), .BIT_OF_H(3), .SIZE(S),
                      .WIN_SCORE(WIN), .POINT_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .player_top(player_top), .player_down(player_down), .row_sel(row_sel),
    .row_out(row_out), .ball_x(ball_x), .ball_y(ball_y),
    .score_top(score_top), .score_down(score_down), .hit(hit), .game_over(game_over));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over
  int ph, mx, my, mdx, mdy, mst, msd, mhold, mhit, mserve, mrow;
  int hits_seen = 0, overs_seen = 0;

  function automatic int clampp(input int p);
    return (p > W - S) ? W - S : p;
  endfunction

  function automatic int render(input int rs);
    int m = 0;
    if (rs == 0)     for (int c = clampp(player_top);  c < clampp(player_top)  + S; c++) m |= (1 << c);
    if (rs == H - 1) for (int c = clampp(player_down); c < clampp(player_down) + S; c++) m |= (1 << c);
    if (ph != 0 && rs == my) m |= (1 << mx);
    return m;
  endfunction

  task automatic model_reset();
    ph = 0; mx = W/2; my = H/2; mdx = 1; mdy = 1; mst = 0; msd = 0;
    mhold = 0; mhit = 0; mserve = 1; mrow = 0;
  endtask

  task automatic serve();
    ph = 1; mx = W/2; my = H/2; mdx = 1; mdy = mserve;
  endtask

  // Advance the model across one rising edge with the current inputs
  task automatic model_step();
    int nx, ty, p;
    mrow = render(int'(row_sel));
    mhit = 0;
    case (ph)
      0: if (start) serve();
      1: if (tick) ph = 2;
      2: if (tick) begin
        nx = mx + mdx;
        if (nx < 0 || nx >= W) begin mdx = -mdx; nx = mx + mdx; end
        ty = my + mdy;
        if (ty == 0 || ty == H - 1) begin
          p = (ty == 0) ? clampp(player_top) : clampp(player_down);
          if (nx >= p && nx < p + S) begin
            mdy = -mdy; mx = nx; mhit = 1;
`ifdef PONG_EDGE_DEFLECT_EN
            if (nx == p) mdx = -1;
            else if (nx == p + S - 1) mdx = 1;
`endif
          end else begin
            mx = nx; my = ty; ph = 3;
            if (ty == 0) begin if (msd < 15) msd++; mserve = -1; end
            else begin if (mst < 15) mst++; mserve = 1; end
          end
        end else begin
          mx = nx; my = ty;
        end
      end
      3: if (tick) begin
        mhold++;
        if (mhold == HOLD) begin
          mhold = 0;
          if (mst == WIN || msd == WIN) ph = 4; else serve();
        end
      end
      4: if (start) begin mst = 0; msd = 0; mserve = 1; serve(); end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".ball_x"},     int'(ball_x),     mx);
    check({ctx, ".ball_y"},     int'(ball_y),     my);
    check({ctx, ".score_top"},  int'(score_top),  mst);
    check({ctx, ".score_down"}, int'(score_down), msd);
    check({ctx, ".hit"},        int'(hit),        mhit);
    check({ctx, ".game_over"},  int'(game_over),  (ph == 4) ? 1 : 0);
    check({ctx, ".row_out"},    int'(row_out),    mrow);
  endtask

  task automatic randomize_inputs();
    int track;
    tick  = ($urandom_range(0, 1) == 0);
    start = ($urandom_range(0, 15) == 0);
    row_sel = 3'($urandom_range(0, 7));
    // Half the time paddles follow the ball so rallies and hits occur
    track = mx - int'($urandom_range(0, 1));
    if (track < 0) track = 0;
    player_top  = $urandom_range(0, 1) ? 3'(track) : 3'($urandom_range(0, 7));
    player_down = $urandom_range(0, 1) ? 3'(track) : 3'($urandom_range(0, 7));
  endtask

  initial begin
    bit pending_release;
    model_reset();
    pending_release = 1'b0;
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;
    randomize_inputs();
    model_step();

    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      compare_all("run");
      if (hit) hits_seen++;
      if (game_over && ph == 4) overs_seen++;
      if (pending_release) begin
        rst_n = 1'b1;
        pending_release = 1'b0;
        randomize_inputs();
        model_step();
      end else if (cyc == 3000 || cyc == 6000) begin
        // Asynchronous abort mid-game
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("midrst");
        tick = 1'b1; start = 1'b1;
        pending_release = 1'b1;
      end else begin
        randomize_inputs();
        model_step();
      end
    end

    // Clamp render: top paddle at 7 clamps to columns 6..7
    @(negedge clk);
    tick = 1'b0; start = 1'b0; player_top = 3'd7; row_sel = 3'd0;
    model_step();
    @(negedge clk);
    check("clamp.row_out", int'(row_out), mrow);
    check("clamp.mask", int'(row_out) & 8'hC0, 8'hC0);

    check("coverage.hits", (hits_seen > 0) ? 1 : 0, 1);
    check("coverage.over", (overs_seen > 0) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
